// File: rtl/hammer_campaign_ctrl.sv
// Walks the rowhammer engine over a range of victim rows: loads each row, releases the
// engine, collects its bit-flip count, streams it out and keeps campaign totals.
module hammer_campaign_ctrl #(
   parameter int ADDR_WIDTH = 64,
   parameter int WORD_WIDTH = 64,
   parameter int ROW_WIDTH  = 12,
   parameter int ROW_POS    = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
   input  logic [ROW_WIDTH-1:0]  cfg_row_first,
   input  logic [ROW_WIDTH-1:0]  cfg_row_last,
   input  logic [ROW_WIDTH-1:0]  cfg_row_stride,
   input  logic [WORD_WIDTH-1:0] cfg_pattern,
   input  logic                  cfg_invert,
   input  logic [31:0]           cfg_count,
   output logic                  eng_reset,
   output logic [ADDR_WIDTH-1:0] eng_address,
   output logic [WORD_WIDTH-1:0] eng_pattern,
   output logic [31:0]           eng_count,
   input  logic [3:0]            eng_state,
   input  logic [63:0]           eng_flips,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [ROW_WIDTH-1:0]  res_row,
   output logic [63:0]           res_flips,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic [ROW_WIDTH:0]    rows_tested,
   output logic [63:0]           total_flips,
   output logic [ROW_WIDTH-1:0]  max_row,
   output logic [63:0]           max_flips,
   output logic [2:0]            dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_LOAD, S_RUN, S_REPORT, S_NEXT, S_DONE
   } state_t;

   localparam logic [ROW_WIDTH-1:0] ROW_MAX    = '1;
   localparam logic [3:0]           ENG_FINISH = 4'd4;

   state_t                state_q, state_d;
   logic                  load_cnt_q, load_cnt_d;
   logic [ROW_WIDTH-1:0]  cur_row_q, cur_row_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [ROW_WIDTH-1:0]  last_q, last_d;
   logic [ROW_WIDTH-1:0]  stride_q, stride_d;
   logic [WORD_WIDTH-1:0] pattern_q, pattern_d;
   logic                  invert_q, invert_d;
   logic [31:0]           count_q, count_d;
   logic [63:0]           flips_q, flips_d;
   logic [ROW_WIDTH:0]    rows_q, rows_d;
   logic [63:0]           total_q, total_d;
   logic [ROW_WIDTH-1:0]  max_row_q, max_row_d;
   logic [63:0]           max_flips_q, max_flips_d;
   logic                  done_q, done_d;
   logic                  aborted_q, aborted_d;

   logic                  busy_w;
   logic [ROW_WIDTH:0]    row_sum;
   logic [64:0]           flip_sum;

   assign busy_w   = (state_q != S_IDLE) && (state_q != S_DONE);
   assign row_sum  = {1'b0, cur_row_q} + {1'b0, stride_q};
   assign flip_sum = {1'b0, total_q} + {1'b0, flips_q};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         load_cnt_q  <= 1'b0;
         cur_row_q   <= '0;
         base_q      <= '0;
         last_q      <= '0;
         stride_q    <= '0;
         pattern_q   <= '0;
         invert_q    <= 1'b0;
         count_q     <= '0;
         flips_q     <= '0;
         rows_q      <= '0;
         total_q     <= '0;
         max_row_q   <= '0;
         max_flips_q <= '0;
         done_q      <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         load_cnt_q  <= load_cnt_d;
         cur_row_q   <= cur_row_d;
         base_q      <= base_d;
         last_q      <= last_d;
         stride_q    <= stride_d;
         pattern_q   <= pattern_d;
         invert_q    <= invert_d;
         count_q     <= count_d;
         flips_q     <= flips_d;
         rows_q      <= rows_d;
         total_q     <= total_d;
         max_row_q   <= max_row_d;
         max_flips_q <= max_flips_d;
         done_q      <= done_d;
         aborted_q   <= aborted_d;
      end
   end

   // Result port: res_valid is high for the whole REPORT state with res_row/res_flips
   // frozen; the first cycle that also has res_ready high is the transfer.
   always_comb begin
      state_d     = state_q;
      load_cnt_d  = load_cnt_q;
      cur_row_d   = cur_row_q;
      base_d      = base_q;
      last_d      = last_q;
      stride_d    = stride_q;
      pattern_d   = pattern_q;
      invert_d    = invert_q;
      count_d     = count_q;
      flips_d     = flips_q;
      rows_d      = rows_q;
      total_d     = total_q;
      max_row_d   = max_row_q;
      max_flips_d = max_flips_q;
      done_d      = done_q;
      aborted_d   = aborted_q;

      if (abort && busy_w) begin
         state_d   = S_DONE;
         aborted_d = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && !abort) begin
                  base_d      = cfg_base_addr;
                  last_d      = cfg_row_last;
                  stride_d    = (cfg_row_stride == '0) ? ROW_WIDTH'(1) : cfg_row_stride;
                  pattern_d   = cfg_pattern;
                  invert_d    = cfg_invert;
                  count_d     = cfg_count;
                  cur_row_d   = cfg_row_first;
                  rows_d      = '0;
                  total_d     = '0;
                  max_row_d   = '0;
                  max_flips_d = '0;
                  done_d      = 1'b0;
                  aborted_d   = 1'b0;
                  state_d     = S_CHECK;
               end
            end
            S_CHECK: begin
               if (cur_row_q > last_q) begin
                  state_d = S_DONE;
               end else if ((cur_row_q == '0) || (cur_row_q == ROW_MAX)) begin
                  state_d = S_NEXT;
               end else begin
                  load_cnt_d = 1'b0;
                  state_d    = S_LOAD;
               end
            end
            S_LOAD: begin
               if (load_cnt_q) state_d = S_RUN;
               else            load_cnt_d = 1'b1;
            end
            S_RUN: begin
               if (eng_state == ENG_FINISH) begin
                  flips_d = eng_flips;
                  state_d = S_REPORT;
               end
            end
            S_REPORT: begin
               if (res_ready) begin
                  rows_d  = rows_q + (ROW_WIDTH+1)'(1);
                  total_d = flip_sum[64] ? '1 : flip_sum[63:0];
                  if (flips_q > max_flips_q) begin
                     max_row_d   = cur_row_q;
                     max_flips_d = flips_q;
                  end
                  state_d = S_NEXT;
               end
            end
            S_NEXT: begin
               if ((cur_row_q == last_q) || row_sum[ROW_WIDTH]) begin
                  state_d = S_DONE;
               end else begin
                  cur_row_d = row_sum[ROW_WIDTH-1:0];
                  state_d   = S_CHECK;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end

      if (state_d == S_DONE) done_d = 1'b1;
   end

   // Row field of the base address is overwritten by the row under test.
   always_comb begin
      eng_address = base_q;
      eng_address[ROW_POS +: ROW_WIDTH] = cur_row_q;
   end

   assign eng_reset   = (state_q != S_RUN);
   assign eng_pattern = (invert_q && rows_q[0]) ? ~pattern_q : pattern_q;
   assign eng_count   = count_q;
   assign res_valid   = (state_q == S_REPORT);
   assign res_row     = cur_row_q;
   assign res_flips   = flips_q;
   assign busy        = busy_w;
   assign done        = done_q;
   assign aborted     = aborted_q;
   assign rows_tested = rows_q;
   assign total_flips = total_q;
   assign max_row     = max_row_q;
   assign max_flips   = max_flips_q;
   assign dbg_state_o = state_q;

endmodule
